// File: rtl/word_plot_sequencer.sv
// Paces per-character plot requests for a buffered word onto VGA_character_drawing,
// handshaking on ready_to_start_character and reporting completion or a missing acknowledge.
module word_plot_sequencer #(
  parameter int unsigned CHAR_W      = 8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic [4:0] len,
  input  logic [8:0] x_base,
  input  logic [8:0] y_base,
  input  logic       clear_mode,
  input  logic       ready_to_start_character,
  output logic [7:0] address,
  output logic [8:0] x_input,
  output logic [8:0] y_input,
  output logic       enable_character_plot,
  output logic       enable_clear,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned XW    = 9;
  localparam int unsigned LW    = 5;
  localparam int unsigned CW    = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_READY, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_buf [DEPTH];
  logic [AW-1:0]   r_idx, w_idx_nxt;
  logic [XW-1:0]   r_xpos, w_xpos_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_err, w_err_nxt;
  logic [LW-1:0]   r_len;
  logic [XW-1:0]   r_ybase;
  logic            r_clear_mode;
  logic            w_accept;
  logic            w_clear_nxt;
  logic            w_busy_nxt;
  logic [LW-1:0]   w_len_sat;

  logic [DW-1:0]   r_address;
  logic [XW-1:0]   r_x;
  logic [XW-1:0]   r_y;
  logic            r_plot;
  logic            r_clear;
  logic            r_busy;
  logic            r_done;

  assign w_accept    = start && (r_state == S_IDLE);
  assign w_len_sat   = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
  assign w_clear_nxt = w_accept ? clear_mode : r_clear_mode;
  assign w_busy_nxt  = (w_state_nxt == S_WAIT_READY) || (w_state_nxt == S_ISSUE) ||
                       (w_state_nxt == S_WAIT_ACK)   || (w_state_nxt == S_WAIT_DONE);

  // Character buffer: loadable only while the sequencer is not busy, never reset.
  always_ff @(posedge clk) begin
    if (wr_en && !r_busy) r_buf[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state plus next values of the word-progress registers.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_xpos_nxt  = r_xpos;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_idx_nxt   = '0;
          w_xpos_nxt  = x_base;
          w_err_nxt   = 1'b0;
          w_state_nxt = (len == '0) ? S_DONE : S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        if (ready_to_start_character) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!ready_to_start_character) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (ready_to_start_character) begin
          if (({1'b0, r_idx} + LW'(1)) == r_len) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + AW'(1);
            w_xpos_nxt  = r_xpos + XW'(CHAR_W);
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Progress registers and outputs, loaded from the upcoming state so they line up with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx        <= '0;
      r_xpos       <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_len        <= '0;
      r_ybase      <= '0;
      r_clear_mode <= 1'b0;
      r_address    <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_plot       <= 1'b0;
      r_clear      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_xpos <= w_xpos_nxt;
      r_cnt  <= w_cnt_nxt;
      r_err  <= w_err_nxt;
      if (w_accept) begin
        r_len        <= w_len_sat;
        r_ybase      <= y_base;
        r_clear_mode <= clear_mode;
      end
      if (w_state_nxt == S_ISSUE) begin
        r_address <= r_buf[w_idx_nxt];
        r_x       <= w_xpos_nxt;
        r_y       <= r_ybase;
      end
      r_plot  <= (w_state_nxt == S_ISSUE);
      r_clear <= (w_state_nxt != S_IDLE) ? w_clear_nxt : 1'b0;
      r_busy  <= w_busy_nxt;
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign address               = r_address;
  assign x_input               = r_x;
  assign y_input               = r_y;
  assign enable_character_plot = r_plot;
  assign enable_clear          = r_clear;
  assign busy                  = r_busy;
  assign done                  = r_done;
  assign err                   = r_err;

endmodule
